// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared types, RV32M funct3 encodings and decode helpers for the
//            iterative multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [2:0] c_F3_MUL    = 3'b000;
    localparam logic [2:0] c_F3_MULH   = 3'b001;
    localparam logic [2:0] c_F3_MULHSU = 3'b010;
    localparam logic [2:0] c_F3_MULHU  = 3'b011;
    localparam logic [2:0] c_F3_DIV    = 3'b100;
    localparam logic [2:0] c_F3_DIVU   = 3'b101;
    localparam logic [2:0] c_F3_REM    = 3'b110;
    localparam logic [2:0] c_F3_REMU   = 3'b111;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic a_signed(input logic [2:0] f3);
        return (f3 == c_F3_MULH) || (f3 == c_F3_MULHSU) ||
               (f3 == c_F3_DIV)  || (f3 == c_F3_REM);
    endfunction

    function automatic logic b_signed(input logic [2:0] f3);
        return (f3 == c_F3_MULH) || (f3 == c_F3_DIV) || (f3 == c_F3_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_if
// Purpose  : Request/response bundle between execute-stage control and the
//            multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output start, funct3, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit_div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring-division iteration on magnitudes.
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic [DATA_WIDTH-1:0] i_rem,
    input  wire logic [DATA_WIDTH-1:0] i_divisor,
    input  wire logic                  i_bit,
    output logic      [DATA_WIDTH-1:0] o_rem,
    output logic                       o_q
);
    logic [DATA_WIDTH:0] w_shift;
    logic [DATA_WIDTH:0] w_trial;

    // Partial remainder is always below the divisor, so W+1 bits hold the trial.
    assign w_shift = {i_rem, i_bit};
    assign w_trial = w_shift - {1'b0, i_divisor};
    assign o_q     = ~w_trial[DATA_WIDTH];
    assign o_rem   = o_q ? w_trial[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Multi-cycle RV32M multiply/divide (shift-add / restoring divide).
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    muldiv_unit_if.slave bus
);
    localparam int c_CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CW-1:0]       c_LAST = c_CW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] c_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                  r_state;
    logic [c_CW-1:0]         r_cnt;
    logic [2:0]              r_f3;
    logic                    r_neg;
    logic                    r_sa;
    logic [DATA_WIDTH-1:0]   r_opnd;
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_sa, w_sb;
    logic [DATA_WIDTH-1:0]   w_mag_a, w_mag_b;
    logic                    w_b_zero, w_ovf, w_fast;
    logic [DATA_WIDTH-1:0]   w_fast_res;
    logic [DATA_WIDTH:0]     w_hi_sum;
    logic [2*DATA_WIDTH-1:0] w_mul_next, w_div_next, w_acc_next, w_prod;
    logic [DATA_WIDTH-1:0]   w_rem_next, w_quo, w_rem;
    logic                    w_q;
    logic [DATA_WIDTH-1:0]   w_final;

    // Decode at the accepting edge: magnitudes, sign flags and fast paths.
    assign w_sa       = a_signed(bus.funct3) & bus.op_a[DATA_WIDTH-1];
    assign w_sb       = b_signed(bus.funct3) & bus.op_b[DATA_WIDTH-1];
    assign w_mag_a    = w_sa ? -bus.op_a : bus.op_a;
    assign w_mag_b    = w_sb ? -bus.op_b : bus.op_b;
    assign w_b_zero   = (bus.op_b == '0);
    assign w_ovf      = b_signed(bus.funct3) && (bus.op_a == c_MIN) && (&bus.op_b);
    assign w_fast     = is_div(bus.funct3) && (w_b_zero || w_ovf);
    assign w_fast_res = w_b_zero ? (bus.funct3[1] ? bus.op_a : '1)
                                 : (bus.funct3[1] ? '0 : bus.op_a);

    // Multiply: add multiplicand into the high half, shift right; low half
    // starts as the multiplier and is consumed one bit per cycle.
    assign w_hi_sum   = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]} +
                        {1'b0, (r_acc[0] ? r_opnd : '0)};
    assign w_mul_next = {w_hi_sum, r_acc[DATA_WIDTH-1:1]};

    // Divide: high half is the partial remainder, low half shifts the
    // dividend out and the quotient in.
    div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div_step (
        .i_rem     (r_acc[2*DATA_WIDTH-1:DATA_WIDTH]),
        .i_divisor (r_opnd),
        .i_bit     (r_acc[DATA_WIDTH-1]),
        .o_rem     (w_rem_next),
        .o_q       (w_q)
    );
    assign w_div_next = {w_rem_next, r_acc[DATA_WIDTH-2:0], w_q};
    assign w_acc_next = is_div(r_f3) ? w_div_next : w_mul_next;

    assign w_prod = r_neg ? -w_acc_next : w_acc_next;
    assign w_quo  = r_neg ? -w_acc_next[DATA_WIDTH-1:0] : w_acc_next[DATA_WIDTH-1:0];
    assign w_rem  = r_sa  ? -w_acc_next[2*DATA_WIDTH-1:DATA_WIDTH]
                          :  w_acc_next[2*DATA_WIDTH-1:DATA_WIDTH];

    always_comb begin
        w_final = w_rem;
        case (r_f3)
            c_F3_MUL:                             w_final = w_prod[DATA_WIDTH-1:0];
            c_F3_MULH, c_F3_MULHSU, c_F3_MULHU:   w_final = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            c_F3_DIV, c_F3_DIVU:                  w_final = w_quo;
            default:                              w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_neg    <= 1'b0;
            r_sa     <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, FIN: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    if (bus.start) begin
                        r_f3  <= bus.funct3;
                        r_cnt <= '0;
                        r_neg <= w_sa ^ w_sb;
                        r_sa  <= w_sa;
                        if (w_fast) begin
                            r_state  <= FIN;
                            r_done   <= 1'b1;
                            r_result <= w_fast_res;
                        end else begin
                            r_state <= CALC;
                            r_busy  <= 1'b1;
                            r_acc   <= is_div(bus.funct3) ? {{DATA_WIDTH{1'b0}}, w_mag_a}
                                                          : {{DATA_WIDTH{1'b0}}, w_mag_b};
                            r_opnd  <= is_div(bus.funct3) ? w_mag_b : w_mag_a;
                        end
                    end
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state  <= FIN;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_final;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [31:0] c_MIN = 32'h8000_0000;

    logic clk;
    logic rst;
    int   errs   = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    muldiv_unit_if #(.DATA_WIDTH(W)) bus ();

    muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result of one RV32M op, straight from the ISA definition.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        ua, ub, up;
        logic signed [31:0] as32, bs32, r32;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        as32 = a;
        bs32 = b;
        case (f3)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == c_MIN && b == 32'hFFFF_FFFF) return a;
                r32 = as32 / bs32; return r32;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == c_MIN && b == 32'hFFFF_FFFF) return 32'd0;
                r32 = as32 % bs32; return r32;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && (b == 0 || (!f3[0] && a == c_MIN && b == 32'hFFFF_FFFF));
    endfunction

    // Timing model: an accepted op finishes W cycles later, fast ops next cycle.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_res  = m_pend;
            end
        end else begin
            m_done = 1'b0;
            if (bus.start) begin
                m_pend = ref_op(bus.funct3, bus.op_a, bus.op_b);
                if (is_fast(bus.funct3, bus.op_a, bus.op_b)) begin
                    m_done = 1'b1;
                    m_res  = m_pend;
                end else begin
                    m_left = W;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("busy", {31'd0, bus.busy}, {31'd0, m_left > 0});
            chk("done", {31'd0, bus.done}, {31'd0, m_done});
            chk("result", bus.result, m_res);
            if (bus.busy && bus.done) chk("busy_and_done", 32'd1, 32'd0);
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return c_MIN;
            3:       return $urandom_range(0, 9);
            4:       return -$urandom_range(1, 9);
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_done(input bit drop, input bit repulse, output int lat, output int nb);
        lat = 0;
        nb  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (drop && k == 1) begin
                bus.start  = 1'b0;
                bus.funct3 = 3'($urandom);
                bus.op_a   = $urandom;
                bus.op_b   = $urandom;
            end
            if (repulse && k == 5) begin
                bus.start  = 1'b1;
                bus.funct3 = 3'($urandom);
                bus.op_a   = pick();
                bus.op_b   = pick();
            end
            if (repulse && k == 6) bus.start = 1'b0;
            if (bus.busy) nb++;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit fast,
                          input bit repulse);
        int lat, nb;
        chk({nm, "_model"}, ref_op(f3, a, b), exp);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        wait_done(1'b1, repulse, lat, nb);
        chk({nm, "_latency"}, lat, fast ? 32'd1 : 32'd33);
        chk({nm, "_busy_cycles"}, nb, fast ? 32'd0 : 32'd32);
        chk({nm, "_result"}, bus.result, exp);
    endtask

    initial begin
        int lat, nb, ndone;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_result", bus.result, 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        run_op("mul",    3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 0);
        run_op("mulh",   3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0, 0);
        run_op("div",    3'd4, -32'd7, 32'd2, 32'hFFFF_FFFD, 0, 0);
        run_op("rem",    3'd6, -32'd7, 32'd2, 32'hFFFF_FFFF, 0, 0);
        run_op("divu",   3'd5, 32'd100, 32'd7, 32'd14, 0, 0);
        run_op("remu",   3'd7, 32'd100, 32'd7, 32'd2, 0, 0);
        run_op("divu_z", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("rem_z",  3'd6, 32'd5, 32'd0, 32'd5, 1, 0);
        run_op("div_ov", 3'd4, c_MIN, 32'hFFFF_FFFF, c_MIN, 1, 0);
        run_op("rem_ov", 3'd6, c_MIN, 32'hFFFF_FFFF, 32'd0, 1, 0);
        run_op("repulse", 3'd4, -32'd100, 32'd7, 32'hFFFF_FFF2, 0, 1);

        // Start held through FIN: second op accepted back-to-back.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'd7;
        bus.op_b   = 32'hFFFF_FFFD;
        @(negedge clk);
        bus.funct3 = 3'd5;
        bus.op_a   = 32'd100;
        bus.op_b   = 32'd7;
        wait_done(1'b0, 1'b0, lat, nb);
        chk("b2b_first_latency", lat, 32'd32);
        chk("b2b_first_result", bus.result, 32'hFFFF_FFEB);
        wait_done(1'b1, 1'b0, lat, nb);
        chk("b2b_second_latency", lat, 32'd33);
        chk("b2b_second_busy", nb, 32'd32);
        chk("b2b_second_result", bus.result, 32'd14);

        // Reset in the middle of a calculation.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = 3'd5;
        bus.op_a   = 32'd1000;
        bus.op_b   = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("midrst_no_done", ndone, 32'd0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            bus.start  = ($urandom_range(0, 3) == 0);
            bus.funct3 = 3'($urandom);
            bus.op_a   = pick();
            bus.op_b   = pick();
        end
        bus.start = 1'b0;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M multiply/divide unit placed beside the single-cycle ALU in the execute stage. It consumes the register-file read operands (rs1, rs2) and the instruction funct3. It returns a DATA_WIDTH result to the write-back path after an iterative shift-add or restoring-divide sequence. While it works it raises busy so that control can stall the PC and hold the register write.

## Interface
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE or FIN
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  DATA_WIDTH  rs1 value, captured on accepting edge
- op_b  in  DATA_WIDTH  rs2 value, captured on accepting edge
- busy  out  1  high while in CALC
- done  out  1  one-cycle pulse, high exactly while in FIN
- result  out  DATA_WIDTH  final value; valid in FIN and held until the next accepted start or reset

## Operation
- States: IDLE, CALC, FIN.
- IDLE or FIN with start=1 at an edge:
  - Capture funct3 and operand magnitudes; record the sign flags.
  - Clear the iteration counter and go to CALC.
- Start is ignored in CALC; operands and funct3 may change freely after capture.
- FIN with start=0 goes to IDLE. FIN with start=1 is a back-to-back accept, and done drops.
- Signedness:
  - a is signed for MULH, MULHSU, DIV, REM.
  - b is signed for MULH, DIV, REM.
  - MUL is sign-agnostic because only the low half is returned.
- Multiply:
  - 2·DATA_WIDTH accumulator; radix-2 shift-add, one bit of b per CALC cycle.
  - If sign_a XOR sign_b, negate the full 2W product (two's complement).
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Divide:
  - Restoring division, one quotient bit per CALC cycle.
  - Quotient is negated if sign_a XOR sign_b; remainder takes the sign of the dividend.
- Fast paths, decided at the accepting edge, go straight from IDLE/FIN to FIN with no CALC:
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return op_a unchanged.
  - Signed overflow (DIV/REM, op_a = 1 followed by zeros, op_b = all ones): DIV returns op_a, REM returns 0.
- All arithmetic is modulo 2^DATA_WIDTH per half. There are no exceptions and no flags.

## Timing
- Reset, asynchronous: state=IDLE, busy=0, done=0, result=0, counter=0, accumulators=0.
- Reset mid-CALC aborts the operation. No done is produced, and result reads 0.
- Normal latency:
  - Edge E0 accepts start.
  - Edges E1..E(DATA_WIDTH) perform the iterations.
  - The FIN transition and sign fix-up occur at E(DATA_WIDTH).
  - done is high in the cycle after E(DATA_WIDTH), i.e. DATA_WIDTH+1 cycles after the start cycle (33 for W=32).
- Fast-path latency: done is high in the cycle after E0.
- busy is high for exactly DATA_WIDTH cycles on the normal path and never on the fast path.
- done and busy are never high together.
- result updates only on the FIN entry edge (written 0 by reset), and is registered with no combinational path from the inputs.
- Back-to-back throughput: one op per DATA_WIDTH+1 cycles.

## Structure
- Package muldiv_pkg holds:
  - the state enum (IDLE, CALC, FIN);
  - funct3 localparams for the eight RV32M ops;
  - helper functions is_div(funct3) and a_signed/b_signed(funct3).
- Sub-module div_step, combinational: one restoring iteration. Inputs are the partial remainder, divisor and next dividend bit; outputs are the new remainder and quotient bit.
- The multiply step stays inline.
- Target size is 150–250 lines of RTL.

## Test plan
- MUL, op_a=7, op_b=0xFFFFFFFD (-3) → result 0xFFFFFFEB. done in cycle 33 after the start cycle, busy high for 32 cycles. MULH on the same operands → 0xFFFFFFFF.
- MULHU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU, op_a=0xFFFFFFFF (-1), op_b=2 → 0xFFFFFFFF.
- DIV, -7 / 2 → 0xFFFFFFFD. REM, -7 / 2 → 0xFFFFFFFF. DIVU, 100 / 7 → 14. REMU, 100 / 7 → 2.
- Divide by zero:
  - DIVU 5/0 → 0xFFFFFFFF, and REM 5/0 → 5.
  - Both paths: done in the cycle right after the start edge, busy never asserted.
- Signed overflow:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM on the same operands → 0.
  - Both paths take the 1-cycle fast path.
- Control sequencing:
  - start re-pulsed mid-CALC with new operands is ignored and the original result is delivered.
  - start held high in FIN is accepted back-to-back.
  - rst asserted at CALC cycle 10 → busy=0, done=0, result=0 immediately, and no done afterwards.
